// File: rtl/branch_target_predictor.sv
// Branch target buffer with 2-bit direction counters for the IF stage.
// Lookup is combinational; decode-stage resolutions train it one per cycle.
module branch_target_predictor #(
  parameter int XLEN    = 64,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 10,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  lookup_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             upd_valid,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target,
  input  logic             upd_is_jump,
  input  logic             upd_pred_taken,
  input  logic [XLEN-1:0]  upd_pred_target,
  input  logic             flush,
  output logic             upd_mispredict,
  output logic [CNT_W-1:0] n_updates,
  output logic [CNT_W-1:0] n_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic             jump_q   [ENTRIES];

  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic             l_hit;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             unused_pc;

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[IDX_W+2 +: TAG_W];
  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

  assign pred_taken  = l_hit && (jump_q[l_idx] || ctr_q[l_idx][1]);
  assign pred_target = pred_taken ? target_q[l_idx]
                                  : lookup_pc + XLEN'(4);

  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[IDX_W+2 +: TAG_W];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Only index and tag bits of upd_pc select an entry.
  assign unused_pc = ^upd_pc;

  assign upd_mispredict = upd_valid &&
    ((upd_pred_taken != upd_taken) ||
     (upd_taken && (upd_pred_target != upd_target)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
        jump_q[i]   <= 1'b0;
      end
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd_valid) begin
      if (u_hit) begin
        if (upd_is_jump) begin
          ctr_q[u_idx] <= 2'b11;
        end else if (upd_taken) begin
          if (ctr_q[u_idx] != 2'b11) begin
            ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
          end
        end else if (ctr_q[u_idx] != 2'b00) begin
          ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
        end
        if (upd_taken) begin
          target_q[u_idx] <= upd_target;
        end
        jump_q[u_idx] <= upd_is_jump;
      end else if (upd_taken) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= upd_target;
        jump_q[u_idx]   <= upd_is_jump;
        ctr_q[u_idx]    <= upd_is_jump ? 2'b11 : 2'b10;
      end
    end
  end

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_updates     <= '0;
      n_mispredicts <= '0;
    end else begin
      if (upd_valid && (n_updates != '1)) begin
        n_updates <= n_updates + CNT_W'(1);
      end
      if (upd_mispredict && (n_mispredicts != '1)) begin
        n_mispredicts <= n_mispredicts + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor.
// Narrow perf counters so saturation is reachable quickly.
module tb_branch_target_predictor;

  localparam int XLEN  = 64;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [XLEN-1:0]  lookup_pc;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic             upd_valid;
  logic [XLEN-1:0]  upd_pc;
  logic             upd_taken;
  logic [XLEN-1:0]  upd_target;
  logic             upd_is_jump;
  logic             upd_pred_taken;
  logic [XLEN-1:0]  upd_pred_target;
  logic             flush;
  logic             upd_mispredict;
  logic [CNT_W-1:0] n_updates;
  logic [CNT_W-1:0] n_mispredicts;

  int checks = 0;
  int errors = 0;

  branch_target_predictor #(
    .XLEN(XLEN), .ENTRIES(16), .TAG_W(10), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .lookup_pc(lookup_pc),
    .pred_taken(pred_taken),
    .pred_target(pred_target),
    .upd_valid(upd_valid),
    .upd_pc(upd_pc),
    .upd_taken(upd_taken),
    .upd_target(upd_target),
    .upd_is_jump(upd_is_jump),
    .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target),
    .flush(flush),
    .upd_mispredict(upd_mispredict),
    .n_updates(n_updates),
    .n_mispredicts(n_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic look(input string tag,
                      input logic [XLEN-1:0] pc,
                      input logic t,
                      input logic [XLEN-1:0] tgt);
    lookup_pc = pc;
    #1;
    check({tag, "_taken"}, 64'(pred_taken), 64'(t));
    check({tag, "_target"}, pred_target, tgt);
  endtask

  task automatic upd(input logic [XLEN-1:0] pc,
                     input logic t,
                     input logic [XLEN-1:0] tgt,
                     input logic j,
                     input logic pt,
                     input logic [XLEN-1:0] ptgt,
                     input logic fl);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = t;
    upd_target      = tgt;
    upd_is_jump     = j;
    upd_pred_taken  = pt;
    upd_pred_target = ptgt;
    flush           = fl;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic cnt(input string tag,
                     input int u,
                     input int m);
    check({tag, "_nupd"}, 64'(n_updates), 64'(u));
    check({tag, "_nmis"}, 64'(n_mispredicts), 64'(m));
  endtask

  initial begin
    reset           = 1'b1;
    lookup_pc       = 64'h100;
    upd_valid       = 1'b0;
    upd_pc          = '0;
    upd_taken       = 1'b0;
    upd_target      = '0;
    upd_is_jump     = 1'b0;
    upd_pred_taken  = 1'b0;
    upd_pred_target = '0;
    flush           = 1'b0;
    #2;
    look("rst", 64'h100, 1'b0, 64'h104);
    cnt("rst", 0, 0);
    look("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    upd(64'h100, 1'b1, 64'h80, 1'b0, 1'b0, 64'h104, 1'b0);
    check("alloc_mis", 64'(upd_mispredict), 64'd1);
    look("nobypass", 64'h100, 1'b0, 64'h104);
    tick();
    cnt("alloc", 1, 1);
    look("alloc", 64'h100, 1'b1, 64'h80);

    upd(64'h100, 1'b0, 64'h0, 1'b0, 1'b1, 64'h80, 1'b0);
    check("nt1_mis", 64'(upd_mispredict), 64'd1);
    tick();
    look("nt1", 64'h100, 1'b0, 64'h104);
    cnt("nt1", 2, 2);

    upd(64'h100, 1'b0, 64'h0, 1'b0, 1'b0, 64'h104, 1'b0);
    check("nt2_mis", 64'(upd_mispredict), 64'd0);
    tick();
    look("nt2", 64'h100, 1'b0, 64'h104);
    cnt("nt2", 3, 2);

    upd(64'h100, 1'b1, 64'h80, 1'b0, 1'b0, 64'h104, 1'b0);
    tick();
    look("hyst", 64'h100, 1'b0, 64'h104);
    cnt("hyst", 4, 3);

    upd(64'h100, 1'b1, 64'h80, 1'b0, 1'b0, 64'h104, 1'b0);
    tick();
    look("retrain", 64'h100, 1'b1, 64'h80);
    cnt("retrain", 5, 4);

    look("alias_miss", 64'h140, 1'b0, 64'h144);
    upd(64'h140, 1'b1, 64'h40, 1'b0, 1'b0, 64'h144, 1'b0);
    tick();
    look("alias_new", 64'h140, 1'b1, 64'h40);
    look("alias_old", 64'h100, 1'b0, 64'h104);
    cnt("alias", 6, 5);

    upd(64'h140, 1'b1, 64'h48, 1'b0, 1'b1, 64'h40, 1'b0);
    check("tgt_mis", 64'(upd_mispredict), 64'd1);
    tick();
    look("tgt_upd", 64'h140, 1'b1, 64'h48);

    upd(64'h200, 1'b1, 64'h300, 1'b1, 1'b0, 64'h204, 1'b0);
    tick();
    look("jal", 64'h200, 1'b1, 64'h300);
    look("jal_evict", 64'h140, 1'b0, 64'h144);
    cnt("jal", 8, 7);

    upd(64'h204, 1'b1, 64'h500, 1'b0, 1'b0, 64'h208, 1'b1);
    tick();
    look("flush_a", 64'h200, 1'b0, 64'h204);
    look("flush_b", 64'h204, 1'b0, 64'h208);
    cnt("flush", 9, 8);

    upd(64'h204, 1'b0, 64'h0, 1'b0, 1'b0, 64'h208, 1'b0);
    check("ok_mis", 64'(upd_mispredict), 64'd0);
    tick();
    look("nt_miss", 64'h204, 1'b0, 64'h208);
    cnt("ok", 10, 8);

    for (int i = 0; i < 20; i++) begin
      upd(64'h300, 1'b1, 64'h10, 1'b0, 1'b0, 64'h304, 1'b0);
      tick();
    end
    cnt("sat", 15, 15);
    upd(64'h300, 1'b1, 64'h10, 1'b0, 1'b1, 64'h10, 1'b0);
    tick();
    upd(64'h300, 1'b0, 64'h0, 1'b0, 1'b1, 64'h10, 1'b0);
    tick();
    cnt("sat_hold", 15, 15);

    #3;
    reset = 1'b1;
    #1;
    cnt("async_rst", 0, 0);
    look("async_rst", 64'h300, 1'b0, 64'h304);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
